median_filter_3x3: RTL and testbench
====================================

# median_filter_3x3

Streaming 3x3 median filter for the pixel pipeline, generalised over channel count and channel width, with full valid/ready flow control. Raster pixels enter one per handshake. Two line buffers plus a 3x3 window feed a pipelined per-channel median network. The block emits the valid interior of the frame, (IMAGE_LEN-2) x (IMAGE_HEIGHT-2) pixels, and pulses done when the frame is complete.

## Interface
- IMAGE_LEN, 1080, pixels per row (≥3)
- IMAGE_HEIGHT, 720, rows per frame (≥3)
- CHANNELS, 3, channels per pixel
- CHANNEL_W, 8, bits per channel; PIXEL_W = CHANNELS*CHANNEL_W, channel 0 in LSBs
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  start a frame; honoured only in IDLE
- s_valid_i  in  1  input pixel valid
- s_ready_o  out  1  input ready
- s_pixel_i  in  PIXEL_W  input pixel, raster order
- m_valid_o  out  1  output pixel valid
- m_ready_i  in  1  downstream ready
- m_pixel_o  out  PIXEL_W  filtered pixel
- m_last_o  out  1  last output pixel of a row, qualified by m_valid_o
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle pulse at frame end

## Operation
- FSM IDLE -> RUN on start_i. RUN -> DRAIN when the input handshake for (x=IMAGE_LEN-1, y=IMAGE_HEIGHT-1) occurs. DRAIN -> IDLE once the pipeline is empty and the last output has handshaken; done_o pulses on that transition.
- On start, x/y counters clear. They advance only on the input handshake (s_valid_i && s_ready_o); x wraps at IMAGE_LEN-1 and y increments on the wrap.
- Line buffers: two instances of the existing bram, depth IMAGE_LEN, read-first, indexed by x.
  - LB0 holds row y-1; LB1 holds row y-2.
  - On accept, both are read at x; LB0 is written with s_pixel_i and LB1 with LB0's old value.
  - Contents are not reset.
- Window: 3 columns x 3 rows, shifted left on each accept. The window is valid when x≥2 && y≥2; its centre is (x-1, y-1).
- Median per channel, exact, no rounding:
  - stage A sorts each column (lo/mid/hi);
  - stage B forms max(lo), med(mid), min(hi);
  - stage C outputs the median of those three.
- m_last_o = window valid at x==IMAGE_LEN-1.
- start_i in RUN/DRAIN is ignored. Input beyond the frame is not accepted, because s_ready_o is low outside RUN.

## Timing
- Reset values: s_ready_o=0, m_valid_o=0, m_pixel_o=0, m_last_o=0, busy_o=0, done_o=0, FSM=IDLE, counters 0.
- Global stall: advance = !m_valid_o || m_ready_i. All pipeline registers and bram read enables advance only on advance.
- s_ready_o = (state==RUN) && advance.
- Latency: the input handshake at cycle t gives m_valid_o at t+4 with no stall. Stages: bram read/accept, window, stage A, stage B/C, output register.
- While m_valid_o && !m_ready_i, m_pixel_o and m_last_o are held stable.
- No drops and no duplicates under any valid/ready pattern. Full throughput is one pixel per cycle.
- done_o is asserted in the cycle after the final output handshake.
- Reset mid-frame: within one cycle of rst_n low, all pipeline valids are cleared, outputs return to reset values and the FSM goes to IDLE. Partial frame data is discarded.

## Configuration
- MEDIAN_FILTER_MODE_EN defined: adds input port mode_i [1:0], sampled with each accepted pixel and carried down the pipeline.
  - 0 gives the median.
  - 1 gives the minimum, min of column lo values.
  - 2 gives the maximum, max of column hi values.
  - 3 is treated as 0.
- Undefined: no mode_i port; the output is always the median. Latency is identical in both builds.

## Structure
- median_filter_pkg holds the FSM state enum (IDLE, RUN, DRAIN), the mode enum (MODE_MEDIAN, MODE_MIN, MODE_MAX), and the LATENCY=4 constant.
- Pixel types stay local, because they are parameter-dependent.
- Sub-module sort3: combinational 3-input compare-exchange, parametrised by CHANNEL_W, outputs lo/mid/hi. It is instantiated per column per channel and again for stage C.
- The line buffers reuse the existing bram.

## Test plan
Parameters for all scenarios: IMAGE_LEN=5, IMAGE_HEIGHT=4, CHANNELS=3, CHANNEL_W=8.
- Constant frame, every pixel 0x404040, m_ready_i=1 -> six outputs, all 0x404040, with m_last_o on outputs 3 and 6. done_o pulses once, one cycle after the sixth handshake.
- Impulse: 0xFFFFFF at (2,1), all other pixels 0 -> all six outputs 0.
- Ramp: each channel = x+5y -> output (i,j) = (i+1)+5(j+1), giving the sequence 6,7,8,11,12,13.
- Ramp with m_ready_i high 1 cycle in 3 and s_valid_i random -> the same sequence, each value handshaken exactly once, with m_pixel_o stable while stalled.
- rst_n low for 1 cycle after 7 accepted pixels -> all outputs 0 and state IDLE; a subsequent start with the ramp frame gives the correct full sequence.
- MEDIAN_FILTER_MODE_EN build, ramp frame:
  - mode_i=1 -> i+5j (0,1,2,5,6,7);
  - mode_i=2 -> (i+2)+5(j+2) (12,13,14,17,18,19).

Source files
------------

// File: rtl/median_filter_pkg.sv
// median_filter_pkg: shared FSM/mode types and pipeline latency for median_filter_3x3
package median_filter_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    typedef enum logic [1:0] {MODE_MEDIAN, MODE_MIN, MODE_MAX} mode_e;
    localparam int LATENCY = 4;
endpackage

// File: rtl/bram.sv
// bram: simple dual-port block RAM, registered read-first output, contents not reset
module bram #(
    parameter int DEPTH = 1080,
    parameter int W = 24,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    // read returns the old word when the same address is written in the same cycle
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end
endmodule

// File: rtl/sort3.sv
// sort3: combinational three-input compare-exchange giving lo/mid/hi
module sort3 #(
    parameter int CHANNEL_W = 8
) (
    input  logic [CHANNEL_W-1:0] a,
    input  logic [CHANNEL_W-1:0] b,
    input  logic [CHANNEL_W-1:0] c,
    output logic [CHANNEL_W-1:0] lo,
    output logic [CHANNEL_W-1:0] mid,
    output logic [CHANNEL_W-1:0] hi
);
    logic [CHANNEL_W-1:0] l1, h1, t;
    assign l1  = (a < b) ? a : b;
    assign h1  = (a < b) ? b : a;
    assign hi  = (h1 > c) ? h1 : c;
    assign t   = (h1 > c) ? c : h1;
    assign lo  = (l1 < t) ? l1 : t;
    assign mid = (l1 < t) ? t : l1;
endmodule

// File: rtl/median_filter_3x3.sv
// median_filter_3x3: streaming 3x3 median filter with valid/ready flow control; MEDIAN_FILTER_MODE_EN adds mode_i (median/min/max)
module median_filter_3x3
    import median_filter_pkg::*;
#(
    parameter int IMAGE_LEN = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int CHANNELS = 3,
    parameter int CHANNEL_W = 8,
    localparam int PIXEL_W = CHANNELS * CHANNEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
`ifdef MEDIAN_FILTER_MODE_EN
    input  logic [1:0]         mode_i,
`endif
    input  logic               s_valid_i,
    output logic               s_ready_o,
    input  logic [PIXEL_W-1:0] s_pixel_i,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic [PIXEL_W-1:0] m_pixel_o,
    output logic               m_last_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int XW = $clog2(IMAGE_LEN);
    localparam int YW = $clog2(IMAGE_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_LEN - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
    localparam logic [XW-1:0] X_TWO = XW'(2);
    localparam logic [YW-1:0] Y_TWO = YW'(2);

    state_e state, state_d;
    logic done_d, advance, accept, last_in, drain_done;
    logic [XW-1:0] x, p1_x;
    logic [YW-1:0] y, p1_y;
    logic p1_v, w_v, w_last, a_v, a_last;
    logic [PIXEL_W-1:0] p1_pix, lb0_q, lb1_q, res;
    logic [PIXEL_W-1:0] win [3][3];
    logic [CHANNEL_W-1:0] sa_lo [3][CHANNELS], sa_mid [3][CHANNELS], sa_hi [3][CHANNELS];
    logic [CHANNEL_W-1:0] a_lo [3][CHANNELS], a_mid [3][CHANNELS], a_hi [3][CHANNELS];
`ifdef MEDIAN_FILTER_MODE_EN
    logic [1:0] p1_mode, w_mode, a_mode;
`endif

    assign advance    = !m_valid_o || m_ready_i;
    assign s_ready_o  = (state == RUN) && advance;
    assign accept     = s_valid_i && s_ready_o;
    assign busy_o     = state != IDLE;
    assign last_in    = accept && x == X_LAST && y == Y_LAST;
    assign drain_done = !p1_v && !w_v && !a_v && advance;

    // next state: start in IDLE, last input pixel ends RUN, empty pipeline ends DRAIN
    always_comb begin
        state_d = (state == IDLE && start_i) ? RUN :
                  (state == RUN && last_in) ? DRAIN :
                  (state == DRAIN && drain_done) ? IDLE : state;
        done_d = state == DRAIN && drain_done;
    end

    // state register and registered done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            state  <= state_d;
            done_o <= done_d;
        end
    end

    // raster position of the next pixel to be accepted
    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE && start_i)) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            x <= (x == X_LAST) ? '0 : x + 1'b1;
            y <= (x != X_LAST) ? y : (y == Y_LAST) ? '0 : y + 1'b1;
        end
    end

    // LB0 keeps row y-1; LB1 receives LB0's old word once it has been read out
    bram #(.DEPTH(IMAGE_LEN), .W(PIXEL_W)) u_lb0 (
        .clk(clk), .we(accept), .waddr(x), .wdata(s_pixel_i),
        .re(accept), .raddr(x), .rdata(lb0_q)
    );
    bram #(.DEPTH(IMAGE_LEN), .W(PIXEL_W)) u_lb1 (
        .clk(clk), .we(p1_v && advance), .waddr(p1_x), .wdata(lb0_q),
        .re(accept), .raddr(x), .rdata(lb1_q)
    );

    // accept stage: hold the new pixel alongside the line-buffer read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_v <= 1'b0;
        end else if (advance) begin
            p1_v <= accept;
            if (accept) begin
                p1_pix <= s_pixel_i;
                p1_x   <= x;
                p1_y   <= y;
`ifdef MEDIAN_FILTER_MODE_EN
                p1_mode <= mode_i;
`endif
            end
        end
    end

    // window stage: shift in the new column (row y-2, y-1, y)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_v <= 1'b0;
        end else if (advance) begin
            w_v <= p1_v && p1_x >= X_TWO && p1_y >= Y_TWO;
            if (p1_v) begin
                w_last <= p1_x == X_LAST;
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= '{lb1_q, lb0_q, p1_pix};
`ifdef MEDIAN_FILTER_MODE_EN
                w_mode <= p1_mode;
`endif
            end
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_col
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
            sort3 #(.CHANNEL_W(CHANNEL_W)) u_sort (
                .a(win[i][0][k*CHANNEL_W +: CHANNEL_W]),
                .b(win[i][1][k*CHANNEL_W +: CHANNEL_W]),
                .c(win[i][2][k*CHANNEL_W +: CHANNEL_W]),
                .lo(sa_lo[i][k]), .mid(sa_mid[i][k]), .hi(sa_hi[i][k])
            );
        end
    end

    // stage A: sorted columns per channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_v <= 1'b0;
        end else if (advance) begin
            a_v <= w_v;
            if (w_v) begin
                a_lo   <= sa_lo;
                a_mid  <= sa_mid;
                a_hi   <= sa_hi;
                a_last <= w_last;
`ifdef MEDIAN_FILTER_MODE_EN
                a_mode <= w_mode;
`endif
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_med
        logic [CHANNEL_W-1:0] bl_lo, bl_mid, bl_hi, bm_lo, bm_mid, bm_hi;
        logic [CHANNEL_W-1:0] bh_lo, bh_mid, bh_hi, c_lo, c_mid, c_hi;
        logic unused_k;
        sort3 #(.CHANNEL_W(CHANNEL_W)) u_lo (
            .a(a_lo[0][k]), .b(a_lo[1][k]), .c(a_lo[2][k]), .lo(bl_lo), .mid(bl_mid), .hi(bl_hi)
        );
        sort3 #(.CHANNEL_W(CHANNEL_W)) u_mid (
            .a(a_mid[0][k]), .b(a_mid[1][k]), .c(a_mid[2][k]), .lo(bm_lo), .mid(bm_mid), .hi(bm_hi)
        );
        sort3 #(.CHANNEL_W(CHANNEL_W)) u_hi (
            .a(a_hi[0][k]), .b(a_hi[1][k]), .c(a_hi[2][k]), .lo(bh_lo), .mid(bh_mid), .hi(bh_hi)
        );
        sort3 #(.CHANNEL_W(CHANNEL_W)) u_c (
            .a(bl_hi), .b(bm_mid), .c(bh_lo), .lo(c_lo), .mid(c_mid), .hi(c_hi)
        );
        assign unused_k = ^{bl_lo, bl_mid, bm_lo, bm_hi, bh_mid, bh_hi, c_lo, c_hi};
`ifdef MEDIAN_FILTER_MODE_EN
        assign res[k*CHANNEL_W +: CHANNEL_W] = (a_mode == MODE_MIN) ? bl_lo :
                                               (a_mode == MODE_MAX) ? bh_hi : c_mid;
`else
        assign res[k*CHANNEL_W +: CHANNEL_W] = c_mid;
`endif
    end

    // output register: holds pixel and last flag while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_o <= 1'b0;
            m_pixel_o <= '0;
            m_last_o  <= 1'b0;
        end else if (advance) begin
            m_valid_o <= a_v;
            if (a_v) begin
                m_pixel_o <= res;
                m_last_o  <= a_last;
            end
        end
    end
endmodule

// File: tb/tb_median_filter_3x3.sv
// tb_median_filter_3x3: directed table-driven bench for median_filter_3x3 on a 5x4 frame
module tb_median_filter_3x3;
    import median_filter_pkg::*;
    localparam int L = 5, H = 4, PW = 24;

    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, s_valid_i = 1'b0, m_ready_i = 1'b0;
    logic [PW-1:0] s_pixel_i = '0;
    logic [1:0] mode_i = 2'd0;
    logic s_ready_o, m_valid_o, m_last_o, busy_o, done_o;
    logic [PW-1:0] m_pixel_o;
    int total = 0, bad = 0;

    typedef struct {
        int pat;
        bit stall;
        logic [1:0] md;
        logic [5:0][PW-1:0] exp;
    } vec_t;
    vec_t vt[$];

    median_filter_3x3 #(.IMAGE_LEN(L), .IMAGE_HEIGHT(H), .CHANNELS(3), .CHANNEL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
`ifdef MEDIAN_FILTER_MODE_EN
        .mode_i(mode_i),
`endif
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_pixel_i(s_pixel_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_pixel_o(m_pixel_o),
        .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] rep(input int v);
        return {3{8'(v)}};
    endfunction

    function automatic logic [5:0][PW-1:0] seq(input int a0, a1, a2, a3, a4, a5);
        return {rep(a5), rep(a4), rep(a3), rep(a2), rep(a1), rep(a0)};
    endfunction

    function automatic logic [PW-1:0] pix(input int pat, input int x, input int y);
        return pat == 0 ? 24'h404040 : pat == 1 ? ((x == 2 && y == 1) ? 24'hFFFFFF : 24'h0) : rep(x + 5 * y);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_frame(input int pat, input bit stall, input logic [1:0] md, input logic [5:0][PW-1:0] exp);
        int sent = 0, got = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_hs = -10, acc_cyc = 0;
        logic was_stall = 1'b0, held_last = 1'b0;
        logic [PW-1:0] held_pix = '0;
        mode_i = md;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        while (cyc < 500 && !(done_cnt > 0 && cyc > done_cyc + 2)) begin
            s_valid_i = (sent < L * H) && (stall ? ($urandom_range(0, 1) == 1) : 1'b1);
            s_pixel_i = pix(pat, sent % L, sent / L);
            m_ready_i = stall ? (cyc % 3 == 0) : 1'b1;
            #1;
            if (was_stall) begin
                chk("hold_valid", 32'(m_valid_o), 32'd1);
                chk("hold_pixel", 32'(m_pixel_o), 32'(held_pix));
                chk("hold_last", 32'(m_last_o), 32'(held_last));
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_timing", 32'(cyc), 32'(last_hs + 1));
                chk("done_outputs", 32'(got), 32'd6);
            end
            if (s_valid_i && s_ready_o) begin
                if (sent == 2 * L + 2) acc_cyc = cyc;
                sent++;
            end
            if (m_valid_o && m_ready_i) begin
                if (got < 6) begin
                    chk($sformatf("pixel%0d", got), 32'(m_pixel_o), 32'(exp[got]));
                    chk($sformatf("last%0d", got), 32'(m_last_o), 32'(got == 2 || got == 5));
                    if (got == 0 && !stall) chk("latency", 32'(cyc - acc_cyc), 32'(LATENCY));
                end else begin
                    chk("extra_output", 32'(got), 32'd5);
                end
                got++;
                last_hs = cyc;
            end
            was_stall = m_valid_o && !m_ready_i;
            held_pix = m_pixel_o;
            held_last = m_last_o;
            cyc++;
            @(negedge clk);
        end
        s_valid_i = 1'b0;
        chk("accepted", 32'(sent), 32'(L * H));
        chk("out_count", 32'(got), 32'd6);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("busy_end", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int n;
        vt.push_back('{pat: 0, stall: 1'b0, md: 2'd0, exp: seq(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40)});
        vt.push_back('{pat: 1, stall: 1'b0, md: 2'd0, exp: seq(0, 0, 0, 0, 0, 0)});
        vt.push_back('{pat: 2, stall: 1'b0, md: 2'd0, exp: seq(6, 7, 8, 11, 12, 13)});
        vt.push_back('{pat: 2, stall: 1'b1, md: 2'd0, exp: seq(6, 7, 8, 11, 12, 13)});
`ifdef MEDIAN_FILTER_MODE_EN
        vt.push_back('{pat: 2, stall: 1'b0, md: 2'd1, exp: seq(0, 1, 2, 5, 6, 7)});
        vt.push_back('{pat: 2, stall: 1'b0, md: 2'd2, exp: seq(12, 13, 14, 17, 18, 19)});
        vt.push_back('{pat: 2, stall: 1'b1, md: 2'd3, exp: seq(6, 7, 8, 11, 12, 13)});
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready_o), 32'd0);
        chk("rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("rst_m_pixel", 32'(m_pixel_o), 32'd0);
        chk("rst_m_last", 32'(m_last_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vt.size(); i++) run_frame(vt[i].pat, vt[i].stall, vt[i].md, vt[i].exp);
        mode_i = 2'd0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        m_ready_i = 1'b1;
        n = 0;
        for (int g = 0; g < 50 && n < 7; g++) begin
            s_valid_i = 1'b1;
            s_pixel_i = pix(2, n % L, n / L);
            #1;
            if (s_ready_o) n++;
            @(negedge clk);
        end
        chk("mid_accepted", 32'(n), 32'd7);
        chk("mid_busy", 32'(busy_o), 32'd1);
        s_valid_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready_o), 32'd0);
        chk("mid_rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("mid_rst_m_pixel", 32'(m_pixel_o), 32'd0);
        chk("mid_rst_m_last", 32'(m_last_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        run_frame(2, 1'b0, 2'd0, seq(6, 7, 8, 11, 12, 13));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
